pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/interrupt controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RUN       = 3'd0,
    S_LD_STALL  = 3'd1,
    S_INT_DRAIN = 3'd2,
    S_INT_SAVE  = 3'd3,
    S_INT_VEC   = 3'd4
  } state_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_VEC = 2'b10;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID and EX stages.
module hazard_detect (
  input  logic [1:0] id_ra_i,
  input  logic [1:0] id_rb_i,
  input  logic       id_uses_ra_i,
  input  logic       id_uses_rb_i,
  input  logic [1:0] ex_rd_i,
  input  logic       ex_memread_i,
  input  logic       ex_regwrite_i,
  output logic       lu_o
);

  assign lu_o = ex_memread_i & ex_regwrite_i &
                ((id_uses_ra_i & (id_ra_i == ex_rd_i)) |
                 (id_uses_rb_i & (id_rb_i == ex_rd_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: load-use stall, branch flush and interrupt entry
// (drain, save return PC, vector).
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id_ra,
  input  logic [1:0] id_rb,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic [1:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic       branch_taken,
  input  logic       int_req,
  output logic       pc_write,
  output logic       ifid_write,
  output logic [1:0] pc_sel,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       int_save,
  output logic       int_ack,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;

  hazard_detect u_hazard (
    .id_ra_i      (id_ra),
    .id_rb_i      (id_rb),
    .id_uses_ra_i (id_uses_ra),
    .id_uses_rb_i (id_uses_rb),
    .ex_rd_i      (ex_rd),
    .ex_memread_i (ex_memread),
    .ex_regwrite_i(ex_regwrite),
    .lu_o         (lu)
  );

  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // together at the edge; combinational logic below uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    pc_sel     = PC_SEQ;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    int_save   = 1'b0;
    int_ack    = 1'b0;
    busy       = 1'b0;

    // Reset forces all outputs low asynchronously, not just at the next edge.
    if (!rst) begin
      busy = (state_q != S_RUN);
      unique case (state_q)
        S_RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (branch_taken) begin
            pc_sel     = PC_BR;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = S_LD_STALL;
          end else if (int_req) begin
            cnt_d   = 2'(DRAIN_CYCLES - 1);
            state_d = S_INT_DRAIN;
          end
        end
        S_LD_STALL: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          state_d    = S_RUN;
        end
        S_INT_DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          else               state_d = S_INT_SAVE;
        end
        S_INT_SAVE: begin
          int_save   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = S_INT_VEC;
        end
        S_INT_VEC: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          pc_sel     = PC_VEC;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          int_ack    = 1'b1;
          state_d    = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] id_ra, id_rb, ex_rd;
  logic       id_uses_ra, id_uses_rb, ex_memread, ex_regwrite;
  logic       branch_taken, int_req;
  logic       pc_write, ifid_write, ifid_flush, idex_flush;
  logic       int_save, int_ack, busy;
  logic [1:0] pc_sel;

  int total = 0;
  int bad   = 0;

  // {pc_write, ifid_write, pc_sel, ifid_flush, idex_flush, int_save, int_ack, busy}
  localparam logic [8:0] E_ZERO = 9'b0_0_00_0_0_0_0_0;
  localparam logic [8:0] E_IDLE = 9'b1_1_00_0_0_0_0_0;
  localparam logic [8:0] E_BR   = 9'b1_1_01_1_1_0_0_0;
  localparam logic [8:0] E_LU   = 9'b0_0_00_0_1_0_0_0;
  localparam logic [8:0] E_LDS  = 9'b1_1_00_0_0_0_0_1;
  localparam logic [8:0] E_DRN  = 9'b0_0_00_1_1_0_0_1;
  localparam logic [8:0] E_SAV  = 9'b0_0_00_1_1_1_0_1;
  localparam logic [8:0] E_VEC  = 9'b1_1_10_1_1_0_1_1;

  logic [8:0] exp_q[$];
  string      name_q[$];

  pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .branch_taken(branch_taken), .int_req(int_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .pc_sel(pc_sel),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .int_save(int_save), .int_ack(int_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: the DUT presents one output vector per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, {pc_write, ifid_write, pc_sel, ifid_flush, idex_flush,
                int_save, int_ack, busy}, e);
    end
  end

  // hz: 0 none, 1 rb load-use, 2 ra load-use, 3 rb match but unused, 4 rb match no load
  task automatic step(input logic r, input logic br, input logic ir, input int hz,
                      input logic [8:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst          = r;
    branch_taken = br;
    int_req      = ir;
    id_ra = 2'd0; id_rb = 2'd3; ex_rd = 2'd2;
    id_uses_ra = 1'b0; id_uses_rb = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;
    case (hz)
      1: begin id_rb = 2'd2; id_uses_rb = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; end
      2: begin id_ra = 2'd1; ex_rd = 2'd1; id_uses_ra = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; end
      3: begin id_rb = 2'd2; ex_memread = 1'b1; ex_regwrite = 1'b1; end
      4: begin id_rb = 2'd2; id_uses_rb = 1'b1; ex_regwrite = 1'b1; end
      default: ;
    endcase
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; branch_taken = 1'b0; int_req = 1'b0;
    id_ra = 2'd0; id_rb = 2'd0; ex_rd = 2'd0;
    id_uses_ra = 1'b0; id_uses_rb = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;

    step(1, 1, 1, 1, E_ZERO, "reset_outputs_zero");
    step(1, 0, 0, 0, E_ZERO, "reset_hold");
    step(0, 0, 0, 0, E_IDLE, "run_idle");

    step(0, 0, 0, 1, E_LU,   "lu_rb_stall");
    step(0, 0, 0, 1, E_LDS,  "ld_stall_no_reeval");
    step(0, 0, 0, 0, E_IDLE, "after_ld_stall");
    step(0, 0, 0, 2, E_LU,   "lu_ra_stall");
    step(0, 0, 0, 0, E_LDS,  "ld_stall_ra");
    step(0, 0, 0, 3, E_IDLE, "no_lu_unused_rb");
    step(0, 0, 0, 4, E_IDLE, "no_lu_not_load");

    step(0, 1, 0, 1, E_BR,   "branch_over_lu");
    step(0, 0, 0, 0, E_IDLE, "no_stall_after_branch");
    step(0, 1, 1, 0, E_BR,   "branch_over_int");
    step(0, 0, 0, 0, E_IDLE, "int_dropped_after_branch");

    step(0, 0, 1, 0, E_IDLE, "int_accept");
    step(0, 1, 0, 1, E_DRN,  "drain1_ignore_br_lu");
    step(0, 1, 1, 1, E_DRN,  "drain2_ignore_br_lu");
    step(0, 0, 0, 0, E_DRN,  "drain3");
    step(0, 1, 0, 0, E_SAV,  "int_save");
    step(0, 1, 0, 1, E_VEC,  "int_vec");
    step(0, 0, 0, 0, E_IDLE, "int_return_run");

    step(0, 0, 1, 0, E_IDLE, "held_accept");
    step(0, 0, 1, 0, E_DRN,  "held_drain1");
    step(0, 0, 1, 0, E_DRN,  "held_drain2");
    step(0, 0, 1, 0, E_DRN,  "held_drain3");
    step(0, 0, 1, 0, E_SAV,  "held_save");
    step(0, 0, 1, 0, E_VEC,  "held_vec");
    step(0, 0, 1, 0, E_IDLE, "held_one_run_cycle");
    step(0, 0, 0, 0, E_DRN,  "held_redrain1");
    step(0, 0, 0, 0, E_DRN,  "held_redrain2");
    step(0, 0, 0, 0, E_DRN,  "held_redrain3");
    step(0, 0, 0, 0, E_SAV,  "held_resave");
    step(0, 0, 0, 0, E_VEC,  "held_revec");
    step(0, 0, 0, 0, E_IDLE, "held_done");

    step(0, 0, 1, 0, E_IDLE, "rst_seq_accept");
    step(0, 0, 0, 0, E_DRN,  "rst_seq_drain1");
    step(0, 0, 0, 0, E_DRN,  "rst_seq_drain2");
    step(0, 0, 0, 0, E_DRN,  "rst_seq_drain3");
    step(1, 0, 0, 0, E_ZERO, "async_rst_in_save");
    step(1, 0, 0, 0, E_ZERO, "rst_held");
    step(0, 0, 0, 0, E_IDLE, "run_after_rst");
    step(0, 0, 0, 0, E_IDLE, "no_ack_after_rst");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
